pipeline_flow_ctrl: RTL and testbench
=====================================

# pipeline_flow_ctrl

Valid/ready flow controller that sequences an external Generic_Pipeline delay line. It tracks a valid bit alongside every pipeline stage and drives the pipeline's CE. It converts the free-running delay line into a back-pressurable stream stage between an upstream producer and a downstream consumer. It sits beside any Generic_Pipeline whose consumer can stall, e.g. adder/trigger paths feeding FIFOs.

## Interface
- LATENCY, 2, stage count of the controlled Generic_Pipeline; must be ≥1.
- WIDTH, 32, data width of the pipeline output.
- OCC_W, 4, OCCUPANCY width; must hold LATENCY+2.
- CLK  input  1  system clock.
- nRST  input  1  asynchronous, active-low reset.
- I_VALID  input  1  upstream data valid; data itself goes straight into the pipeline's I.
- I_READY  output  1  upstream may transfer; transfer = I_VALID & I_READY.
- CE  output  1  clock enable to the Generic_Pipeline.
- PIPE_O  input  WIDTH  Generic_Pipeline O.
- O_DATA  output  WIDTH  downstream data.
- O_VALID  output  1  downstream data valid.
- O_READY  input  1  downstream accepts; transfer = O_VALID & O_READY.
- FLUSH  input  1  synchronous discard of everything in flight.
- OCCUPANCY  output  OCC_W  items held (valid stages plus skid entries).

## Operation
- Valid shift register vld[1..LATENCY]; vld[0] = I_VALID & I_READY.
- On CE, vld[k] ← vld[k-1]; this exactly mirrors data motion in the pipeline.
- Stall is global: CE low freezes every stage. Bubbles are not squeezed out.
- I_READY = CE & ~FLUSH & nRST.
- FLUSH, when high at a clock edge:
  - clears all vld bits and skid entries;
  - any upstream beat in that cycle is not accepted;
  - pipeline data is left stale, because vld gates it.
- FLUSH has priority over every simultaneous push or pop.
- OCCUPANCY = popcount(vld[1..LATENCY]) + skid count, registered, updated every cycle.
- Reset (nRST low, async): vld=0, skid empty, OCCUPANCY=0, O_VALID=0, O_DATA=0, I_READY=0, CE=1.

## Timing
- Unstalled latency: LATENCY+1 cycles from I transfer to O_VALID with SKID, LATENCY without.
- Full throughput, one beat per cycle, while O_READY is held high.
- Without skid:
  - CE = ~vld[LATENCY] | O_READY. This is a combinational O_READY→CE→I_READY path.
  - O_VALID = vld[LATENCY]; O_DATA = PIPE_O.
- With skid:
  - CE = ~vld[LATENCY] | (skid_count≠2), a function of registers only.
  - When CE & vld[LATENCY], PIPE_O is pushed into the skid.
  - O_VALID = skid_count≠0; O_DATA = skid head.
  - Simultaneous push and pop keeps the count constant.
  - Pop from 2 while the head stage is valid: the stall releases the next cycle.
- O_VALID, once high, stays high with O_DATA stable until transfer or FLUSH.

## Configuration
- PIPE_FLOW_SKID_EN defined:
  - 2-entry output skid buffer, registered O_VALID/O_DATA;
  - O_READY has no combinational path to CE or I_READY.
- PIPE_FLOW_SKID_EN undefined:
  - no skid storage; outputs come straight from vld[LATENCY]/PIPE_O;
  - combinational ready path; OCCUPANCY max is LATENCY.

## Structure
- Shared package pipeline_flow_pkg holds the skid depth constant (2) and the OCC_W sizing function, clog2(LATENCY+3).
- One sub-module, pipeline_skid_buffer: a 2-entry register FIFO with push/pop/flush and count. It is instantiated only under PIPE_FLOW_SKID_EN.
- The valid shift register, CE logic and occupancy counter stay in the top.

## Test plan
- Reset mid-stream: LATENCY=2, continuous traffic, nRST pulse low. Required: O_VALID=0, OCCUPANCY=0 and CE=1 immediately; first output comes LATENCY(+1) cycles after the next accepted beat.
- Streaming: 16 beats 0x00..0x0F, O_READY=1. Required: all beats out in order, back-to-back, first at cycle LATENCY+1 (SKID) / LATENCY.
- Backpressure: pipeline full, O_READY=0 for 5 cycles. Required:
  - with SKID: I_READY drops once skid_count=2 and the head stage is valid; OCCUPANCY=LATENCY+2;
  - without SKID: I_READY=0 the same cycle, OCCUPANCY=LATENCY;
  - either way: no beat lost or duplicated after release.
- Bubbles: I_VALID pattern 1,0,1,1,0 with random O_READY. Required: output order matches, O_DATA stable while O_VALID & ~O_READY.
- FLUSH with push and pop in the same cycle at OCCUPANCY=3. Required: OCCUPANCY=0 next cycle, no O_VALID from pre-flush data, the upstream beat is not accepted.
- SKID pop-from-full: skid_count=2 and vld[LATENCY]=1, O_READY pulses 1 cycle. Required: CE high on the following cycle, count returns to 2, ordering preserved.

Source files
------------

// File: rtl/pipeline_flow_pkg.sv
// Shared constants and sizing helper for pipeline_flow_ctrl and its skid buffer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pipeline_flow_pkg;

  // The output skid holds at most two beats: one being presented downstream
  // and one caught from the pipeline head while the stall takes effect.
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  localparam skid_cnt_t SKID_FULL = skid_cnt_t'(SKID_DEPTH);

  // Bits needed to count LATENCY valid stages plus a full skid.
  function automatic int occ_width(input int latency);
    return $clog2(latency + 3);
  endfunction

endpackage

// File: rtl/pipeline_flow_ctrl_skid.sv
// pipeline_skid_buffer: 2-entry register FIFO catching beats leaving the pipeline head (PIPE_FLOW_SKID_EN only).
// Latency: 1 cycle push to out_vld; out_vld/out_dat come straight from registers.
// Backpressure: push ignored when full, pop ignored when empty; flush beats push and pop.
`ifdef PIPE_FLOW_SKID_EN
module pipeline_skid_buffer
  import pipeline_flow_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       cnt,
  output logic [1:0]       cnt_nxt
);

  skid_cnt_t        cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             do_push;
  logic             do_pop;

  // Entries shift toward head on pop, so head is always the oldest beat.
  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    do_push = push & (cnt_q != SKID_FULL);
    do_pop  = pop & (cnt_q != 2'd0);
    if (flush) begin
      // Stale data is left behind; count alone marks the skid empty.
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = push_dat;
          end else begin
            tail_d = push_dat;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new beat lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            head_d = push_dat;
          end else begin
            head_d = tail_q;
            tail_d = push_dat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Skid state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = head_q;
  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule
`endif

// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: valid tracking and CE control for an external Generic_Pipeline; PIPE_FLOW_SKID_EN adds a 2-entry output skid.
// Latency: LATENCY cycles I->O without skid, LATENCY+1 with PIPE_FLOW_SKID_EN.
// Backpressure: global CE stall; O_READY reaches CE/I_READY combinationally without skid, only via registers with it.
module pipeline_flow_ctrl
  import pipeline_flow_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32,
  parameter int OCC_W   = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             CE,
  input  logic [WIDTH-1:0] PIPE_O,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  input  logic             O_READY,
  input  logic             FLUSH,
  output logic [OCC_W-1:0] OCCUPANCY
);

  localparam int SUM_W = occ_width(LATENCY);

  logic [LATENCY:1] vld_q, vld_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [SUM_W-1:0] occ_sum;
  logic [1:0]       skid_cnt_nxt;
  logic             vld_in;
  logic             last_vld;

  assign last_vld = vld_q[LATENCY];

`ifdef PIPE_FLOW_SKID_EN
  logic [1:0] skid_cnt;
  logic       skid_push;
  logic       skid_pop;

  // Stall only when the head stage holds a beat and the skid has no room for it;
  // this depends on registers alone, so O_READY never reaches CE.
  assign CE        = ~last_vld | (skid_cnt != SKID_FULL);
  assign skid_push = CE & last_vld;
  assign skid_pop  = O_VALID & O_READY;

  pipeline_skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (nRST),
    .push     (skid_push),
    .push_dat (PIPE_O),
    .pop      (skid_pop),
    .flush    (FLUSH),
    .out_vld  (O_VALID),
    .out_dat  (O_DATA),
    .cnt      (skid_cnt),
    .cnt_nxt  (skid_cnt_nxt)
  );
`else
  // The head beat leaves directly; advancing is safe only if it is taken.
  assign CE           = ~last_vld | O_READY;
  assign O_VALID      = last_vld;
  // Pipeline data is not reset, so hold the output at zero during reset.
  assign O_DATA       = nRST ? PIPE_O : '0;
  assign skid_cnt_nxt = 2'd0;
`endif

  assign I_READY = CE & ~FLUSH & nRST;
  assign vld_in  = I_VALID & I_READY;

  // Valid bits move exactly when pipeline data moves; flush clears them all.
  always_comb begin
    vld_d = vld_q;
    if (FLUSH) begin
      vld_d = '0;
    end else if (CE) begin
      vld_d[1] = vld_in;
      for (int k = 2; k <= LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  // Occupancy counts the state being loaded this edge, so it is current once registered.
  always_comb begin
    occ_sum = SUM_W'(skid_cnt_nxt);
    for (int k = 1; k <= LATENCY; k++) begin
      occ_sum = occ_sum + SUM_W'(vld_d[k]);
    end
    occ_d = OCC_W'(occ_sum);
  end

  // Valid shift register and occupancy registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_flow_ctrl;

  localparam int LAT = 2;
  localparam int W   = 32;
  localparam int OW  = 4;
`ifdef PIPE_FLOW_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int EXTRA   = SKID ? 1 : 0;
  localparam int MAX_OCC = LAT + (SKID ? 2 : 0);

  logic          clk     = 1'b0;
  logic          nrst    = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready = 1'b0;
  logic          flush   = 1'b0;
  logic [W-1:0]  i_data  = '0;
  logic          i_ready;
  logic          ce;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic [W-1:0]  pipe_o;
  logic [OW-1:0] occupancy;
  logic [W-1:0]  pipe_r [1:LAT];

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted, undelivered beat in arrival order, with
  // the number of pipeline advances it still needs to reach the last stage
  // and whether it has already been caught by the output skid.
  typedef struct {
    logic [W-1:0] d;
    int           steps;
    bit           in_skid;
  } item_t;
  item_t m_q[$];

  int cyc, first_ov, last_ov, n_ov, accepted;
  bit           hold_vld = 1'b0;
  logic [W-1:0] hold_dat = '0;

  always #5 clk = ~clk;

  // The external Generic_Pipeline: a plain CE-enabled delay line.
  always @(posedge clk) begin
    if (ce) begin
      pipe_r[1] <= i_data;
      for (int k = 2; k <= LAT; k++) pipe_r[k] <= pipe_r[k-1];
    end
  end
  assign pipe_o = pipe_r[LAT];

  pipeline_flow_ctrl #(
    .LATENCY (LAT),
    .WIDTH   (W),
    .OCC_W   (OW)
  ) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .I_VALID   (i_valid),
    .I_READY   (i_ready),
    .CE        (ce),
    .PIPE_O    (pipe_o),
    .O_DATA    (o_data),
    .O_VALID   (o_valid),
    .O_READY   (o_ready),
    .FLUSH     (flush),
    .OCCUPANCY (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    cyc = 0; first_ov = -1; last_ov = -1; n_ov = 0; accepted = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model at the
  // falling edge, then advance the model to the state after the rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    int           skid_n;
    bit           head_rdy;
    logic         e_ce, e_ir, e_ov;
    logic [W-1:0] e_od;
    item_t        it;
    i_valid = iv; i_data = id; o_ready = ordy; flush = fl;
    @(negedge clk);
    skid_n = 0;
    foreach (m_q[i]) if (m_q[i].in_skid) skid_n++;
    head_rdy = (m_q.size() > skid_n) && (m_q[skid_n].steps == 0);
    if (SKID) begin
      e_ce = !head_rdy || (skid_n < 2);
      e_ov = (skid_n > 0);
    end else begin
      e_ce = !head_rdy || ordy;
      e_ov = head_rdy;
    end
    e_ir = e_ce && !fl && nrst;
    e_od = (m_q.size() > 0) ? m_q[0].d : '0;
    chk("ce", 64'(ce), 64'(e_ce));
    chk("i_ready", 64'(i_ready), 64'(e_ir));
    chk("o_valid", 64'(o_valid), 64'(e_ov));
    if (e_ov) chk("o_data", 64'(o_data), 64'(e_od));
    chk("occupancy", 64'(occupancy), 64'(m_q.size()));
    if (hold_vld && nrst) begin
      chk("hold_vld", 64'(o_valid), 64'(1));
      chk("hold_dat", 64'(o_data), 64'(hold_dat));
    end
    hold_vld = e_ov && !ordy && !fl && nrst;
    hold_dat = e_od;
    if (o_valid === 1'b1 && ordy && !fl) begin
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
      n_ov++;
    end
    if (!nrst || fl) begin
      m_q.delete();
    end else begin
      if (e_ov && ordy) void'(m_q.pop_front());
      if (e_ce) begin
        foreach (m_q[i]) begin
          if (!m_q[i].in_skid) begin
            if (m_q[i].steps == 0) begin
              if (SKID) m_q[i].in_skid = 1'b1;
            end else begin
              m_q[i].steps = m_q[i].steps - 1;
            end
          end
        end
        if (e_ir && iv) begin
          it.d = id; it.steps = LAT - 1; it.in_skid = 1'b0;
          m_q.push_back(it);
          accepted++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int target;

  initial begin
    // Reset state while upstream is already offering data.
    mark();
    nrst = 1'b0;
    repeat (2) cycle(1'b1, 32'hdead_beef, 1'b1, 1'b0);
    chk("rst_odata", 64'(o_data), 64'(0));
    nrst = 1'b1;

    // Streaming: 16 beats, consumer always ready.
    mark();
    for (int i = 0; i < 16; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    repeat (LAT + 3) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_count", 64'(n_ov), 64'(16));
    chk("stream_first", 64'(first_ov), 64'(LAT + EXTRA));
    chk("stream_b2b", 64'(last_ov - first_ov), 64'(15));

    // Backpressure: fill, then hold O_READY low for 5 more cycles.
    mark();
    for (int i = 0; i < MAX_OCC + 5; i++) cycle(1'b1, 32'h100 + W'(i), 1'b0, 1'b0);
    chk("bp_occ", 64'(occupancy), 64'(MAX_OCC));
    chk("bp_iready", 64'(i_ready), 64'(0));
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_count", 64'(n_ov), 64'(accepted));

    // Bubbles with a randomly stalling consumer.
    mark();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 5; i++)
        cycle(pat[i], 32'h200 + W'(r * 5 + i), 1'($urandom_range(0, 1)), 1'b0);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bub_count", 64'(n_ov), 64'(accepted));

    // Flush together with an upstream push and a downstream pop.
    target = (MAX_OCC < 3) ? MAX_OCC : 3;
    for (int i = 0; i < 8 && m_q.size() < target; i++) cycle(1'b1, 32'h300 + W'(i), 1'b0, 1'b0);
    chk("fl_pre_occ", 64'(occupancy), 64'(target));
    cycle(1'b1, 32'h3ff, 1'b1, 1'b1);
    chk("fl_occ", 64'(occupancy), 64'(0));
    chk("fl_ovalid", 64'(o_valid), 64'(0));
    repeat (LAT + 3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Pop a single beat from a full stage, then stall again.
    mark();
    for (int i = 0; i < MAX_OCC + 2; i++) cycle(1'b1, 32'h400 + W'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h4f0, 1'b1, 1'b0);
    i_valid = 1'b1; o_ready = 1'b0;
    #1;
    chk("pff_ce", 64'(ce), 64'(SKID));
    cycle(1'b1, 32'h4f1, 1'b0, 1'b0);
    chk("pff_occ", 64'(occupancy), 64'(MAX_OCC));
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("pff_count", 64'(n_ov), 64'(accepted));

    // Random traffic with occasional flushes.
    mark();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 32'h1000 + W'(i),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));

    // Reset pulse in the middle of continuous traffic.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h2000 + W'(i), 1'b1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_ovalid", 64'(o_valid), 64'(0));
    chk("rst_mid_occ", 64'(occupancy), 64'(0));
    chk("rst_mid_ce", 64'(ce), 64'(1));
    chk("rst_mid_iready", 64'(i_ready), 64'(0));
    chk("rst_mid_odata", 64'(o_data), 64'(0));
    m_q.delete();
    hold_vld = 1'b0;
    repeat (2) cycle(1'b1, 32'h2100, 1'b1, 1'b0);
    nrst = 1'b1;
    mark();
    cycle(1'b1, 32'h2200, 1'b1, 1'b0);
    repeat (LAT + 3) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("rst_lat", 64'(first_ov), 64'(LAT + EXTRA));
    chk("rst_count", 64'(n_ov), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
